div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand width in bits (legal values 8..64).
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port signed_div_i  input  1  1 = signed divide, 0 = unsigned; sampled with start_i.
REQ-005 SHALL have port opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-006 SHALL have port opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-007 SHALL have port start_i  input  1  request a division; held high until the result is consumed.
REQ-008 SHALL have port annul_i  input  1  cancel the operation in flight (branch/exception flush).
REQ-009 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}, quotient in the low half.
REQ-010 SHALL have port ready_o  output  1  result_o valid.
REQ-011 SHALL have port busy_o  output  1  operation in flight; the execute stage uses it as a stall request.

Function
REQ-012 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-013 In FREE, an edge with start_i=1 and annul_i=0 SHALL latch the operands and mode; the next state is BYZERO if opdata2_i==0, else ON with the iteration counter cleared.
REQ-014 In FREE with start_i=0, or with annul_i=1, the FSM SHALL stay in FREE.
REQ-015 Signed mode SHALL convert each negative operand to its two's-complement magnitude at latch time; unsigned mode uses the operands as-is.
REQ-016 In ON, each edge SHALL perform one radix-2 restoring step using a (WIDTH+1)-bit trial subtraction, then increment the counter.
REQ-017 On the edge where the counter equals WIDTH, the FSM SHALL apply sign correction and enter END:
- quotient is negated when the signed operand signs differ;
- remainder is negated when the signed dividend is negative.
REQ-018 Latency SHALL be exactly WIDTH+2 edges from the accepting edge (inclusive) to ready_o=1, independent of operand values.
REQ-019 BYZERO SHALL last one edge, then enter END with result_o=0, so ready_o=1 two edges after acceptance.
REQ-020 In END, ready_o=1 and result_o SHALL hold stable while start_i=1.
REQ-021 In END, an edge with start_i=0 SHALL return the FSM to FREE, with ready_o=0 and result_o=0.
REQ-022 annul_i=1 in ON or BYZERO SHALL return the FSM to FREE on that edge; no result is produced and ready_o stays 0.
REQ-023 annul_i in END SHALL be ignored; the result is already committed.
REQ-024 busy_o SHALL be 1 exactly in BYZERO and ON.
REQ-025 Signed most-negative / -1 SHALL yield quotient = most-negative value (wrap) and remainder 0, with no flag.
REQ-026 Operand inputs SHALL be ignored outside the accepting edge.

Reset
REQ-027 When rst=0 at an edge, the FSM SHALL go to FREE and the counter and datapath registers SHALL clear.
REQ-028 After reset, ready_o=0, busy_o=0 and result_o=0.
REQ-029 Reset SHALL take priority over every other input, including mid-operation.

Structure
REQ-030 FSM state encodings, DivResultReady/NotReady, DivStart/Stop and the default WIDTH SHALL live in the shared define package.
REQ-031 The block SHALL be a single module with no sub-module; the FSM and datapath are one always block plus combinational trial subtraction.

Verification
REQ-032 Unsigned test (WIDTH=32): 100/7 -> ready_o after 34 edges; quotient 14, remainder 2.
REQ-033 Signed test: -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-034 Overflow test: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-035 Divide-by-zero test: 5/0 -> ready_o after 2 edges; result_o = 0.
REQ-036 Annul test: annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises; a following 9/3 gives quotient 3, remainder 0.
REQ-037 Reset and hold test: rst=0 at iteration 5 -> all outputs 0 next edge; in END, holding start_i for 3 edges keeps result_o stable, and dropping it clears ready_o next edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// handshake level names and the default operand width.
package div_pkg;

  localparam int DivWidthDefault = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with annul and
// divide-by-zero short path; result is {remainder, quotient}.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DivWidthDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CntW = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;

  assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // The partial remainder is always below 2*divisor, so a set top bit means
  // the subtraction fits regardless of the borrow in diff[WIDTH].
  assign partial  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = partial - {1'b0, dvs_q};
  assign fits     = partial[WIDTH] | ~diff[WIDTH];
  assign rem_next = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          if (start_i == DivStart && !annul_i) begin
            quo_q     <= mag1;
            rem_q     <= '0;
            dvs_q     <= mag2;
            neg_quo_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q <= signed_div_i & opdata1_i[WIDTH-1];
            cnt       <= '0;
            busy_o    <= 1'b1;
            state     <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
          end
        end

        DIV_BYZERO: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            result_o <= '0;
            ready_o  <= DivResultReady;
            state    <= DIV_END;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            busy_o <= 1'b0;
            state  <= DIV_FREE;
          end else if (cnt == CntW'(WIDTH)) begin
            result_o <= {(neg_rem_q ? -rem_q : rem_q),
                         (neg_quo_q ? -quo_q : quo_q)};
            ready_o  <= DivResultReady;
            busy_o   <= 1'b0;
            state    <= DIV_END;
          end else begin
            quo_q <= {quo_q[WIDTH-2:0], fits};
            rem_q <= rem_next;
            cnt   <= cnt + CntW'(1);
          end
        end

        DIV_END: begin
          // The result is committed here, so annul_i is deliberately ignored.
          if (start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            state    <= DIV_FREE;
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division on wide integers; x/0 gives 0.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one division, checks latency and result, optionally holds start_i
  // in END for hold edges (with annul pulsed), then drops start_i.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [2*W-1:0] exp;
    int n;
    int explat;
    exp          = model(sgn, a, b);
    explat       = (b == '0) ? 2 : W + 2;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    n = 1;
    check({tag, ".busy"}, 64'(busy_o), 64'd1);
    signed_div_i = 1'($urandom);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    while (!ready_o && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(explat));
    check({tag, ".result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      annul_i = 1'b1;
      tick();
      check({tag, ".hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, ".hold_result"}, result_o, exp);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check({tag, ".drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, ".drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic seen;
    logic [W-1:0] a, b;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset.ready", 64'(ready_o), 64'd0);
    check("reset.busy", 64'(busy_o), 64'd0);
    check("reset.result", result_o, 64'd0);
    rst = 1'b1;
    tick();

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 0);
    check("u100_7.value", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 0);
    run_op("hold", 1'b0, 32'd12345, 32'd67, 3);

    // Annul at iteration 10; start is dropped with it so nothing re-arms.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul.busy", 64'(busy_o), 64'd0);
    check("annul.ready", 64'(ready_o), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o || busy_o) seen = 1'b1;
    end
    check("annul.quiet", 64'(seen), 64'd0);
    run_op("after_annul", 1'b0, 32'd9, 32'd3, 0);

    // Annul during the divide-by-zero cycle.
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    tick();
    check("annul_bz.ready", 64'(ready_o), 64'd0);
    check("annul_bz.busy", 64'(busy_o), 64'd0);

    // Reset at iteration 5.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("midrst.ready", 64'(ready_o), 64'd0);
    check("midrst.busy", 64'(busy_o), 64'd0);
    check("midrst.result", result_o, 64'd0);
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    run_op("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        2: b = 32'd1;
        3: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), 1'($urandom), a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
